maddsub_seq_ctrl: RTL and testbench

- Two-cycle sequencer for MADD/MADDU/MSUB/MSUBU in the EX stage.
- Cycle 1: latches the 64-bit product from the EX multiplier and raises an EX stall request.
- Cycle 2: accumulates the latched product onto the forwarded HI/LO value and releases the stall.
- Also owns the pipeline stall vector, merging the ID-stage and EX-stage stall requests into per-stage hold signals for pc/if/id/ex/mem/wb.

---
 rtl/maddsub_seq_ctrl.sv | 118 +++++++++++
 tb/tb_maddsub_seq_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maddsub_seq_ctrl.sv
// maddsub_seq_ctrl
// Two-cycle EX-stage sequencer for the multiply-accumulate family
// (MADD/MADDU/MSUB/MSUBU). The first cycle captures the multiplier product
// (negated for the subtract forms) and stalls the front of the pipe; the
// second cycle adds it onto the forwarded HI/LO pair and releases the stall.
// The block also merges the ID and EX stall requests into the per-stage
// hold vector used by the pipeline registers.
module maddsub_seq_ctrl #(
  parameter int ACC_W = 64,
  parameter int AOP_W = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [AOP_W-1:0] aluop_i,
  input  logic [ACC_W-1:0] mul_result_i,
  input  logic [31:0]      hi_i,
  input  logic [31:0]      lo_i,
  input  logic             stall_req_id_i,
  input  logic             flush_i,
  output logic [ACC_W-1:0] hilo_wdata_o,
  output logic             done_o,
  output logic             stall_req_ex_o,
  output logic [5:0]       stall_o,
  output logic [1:0]       cnt_o
);

  // aluop encodings of the multiply-accumulate family (AluOpBus values)
  localparam logic [AOP_W-1:0] EXE_MADD_OP  = AOP_W'(8'b1010_0110);
  localparam logic [AOP_W-1:0] EXE_MADDU_OP = AOP_W'(8'b1010_1000);
  localparam logic [AOP_W-1:0] EXE_MSUB_OP  = AOP_W'(8'b1010_1010);
  localparam logic [AOP_W-1:0] EXE_MSUBU_OP = AOP_W'(8'b1010_1011);

  // hold patterns: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
  localparam logic [5:0] HOLD_EX = 6'b001111;
  localparam logic [5:0] HOLD_ID = 6'b000111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [ACC_W-1:0] r_temp;
  logic [1:0]       r_cnt;
  logic             w_isMadd;
  logic             w_isSub;
  logic             w_start;
  logic             w_done;
  logic [ACC_W-1:0] w_hiLo;
  logic [ACC_W-1:0] w_sum;

  // Decode which instruction class is sitting in EX this cycle
  always_comb begin
    w_isMadd = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
               (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    w_isSub  = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
  end

  // State register; reset drops any half-finished sequence
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic; a flush wins over starting or completing a sequence
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_isMadd && !flush_i) begin
          w_start     = 1'b1;
          w_nextState = S_ACC;
        end
      end
      S_ACC: begin
        w_nextState = S_IDLE;
        if (!flush_i) w_done = 1'b1;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Capture the product in cycle one; subtract forms store its negation so
  // cycle two is always a plain add onto HI/LO
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)       r_temp <= '0;
    else if (w_start) r_temp <= w_isSub ? (~mul_result_i + ACC_W'(1)) : mul_result_i;
  end

  // Sequence cycle counter: 1 while the product is latched, 0 otherwise
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                    r_cnt <= 2'd0;
    else if (w_nextState == S_ACC) r_cnt <= 2'd1;
    else                           r_cnt <= 2'd0;
  end

  // HI/LO is taken in the accumulate cycle so late MEM/WB writes are seen;
  // the add wraps modulo 2^ACC_W with no overflow trap
  always_comb begin
    w_hiLo = ACC_W'({hi_i, lo_i});
    w_sum  = r_temp + w_hiLo;
  end

  // Output drive; everything is forced quiet while reset is held
  always_comb begin
    stall_req_ex_o = Rst_n & w_start;
    done_o         = Rst_n & w_done;
    hilo_wdata_o   = (Rst_n && w_done) ? w_sum : '0;
    cnt_o          = Rst_n ? r_cnt : 2'd0;
    stall_o        = 6'b000000;
    if (Rst_n && w_start)             stall_o = HOLD_EX;
    else if (Rst_n && stall_req_id_i) stall_o = HOLD_ID;
  end

endmodule

// File: tb/tb_maddsub_seq_ctrl.sv
// Self-checking bench for maddsub_seq_ctrl: directed test-plan cases, stall
// merging, flush and reset abort, plus a randomized run against a reference
// model that computes each result as {HI,LO} plus or minus the product.
module tb_maddsub_seq_ctrl;

  localparam logic [7:0] OP_MADD  = 8'b1010_0110;
  localparam logic [7:0] OP_MADDU = 8'b1010_1000;
  localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
  localparam logic [7:0] OP_MSUBU = 8'b1010_1011;
  localparam logic [7:0] OP_NOP   = 8'h00;

  logic        Clk;
  logic        Rst_n;
  logic [7:0]  aluop_i;
  logic [63:0] mul_result_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        stall_req_id_i;
  logic        flush_i;
  logic [63:0] hilo_wdata_o;
  logic        done_o;
  logic        stall_req_ex_o;
  logic [5:0]  stall_o;
  logic [1:0]  cnt_o;

  int errors = 0;
  int checks = 0;

  maddsub_seq_ctrl #(.ACC_W(64), .AOP_W(8)) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .aluop_i        (aluop_i),
    .mul_result_i   (mul_result_i),
    .hi_i           (hi_i),
    .lo_i           (lo_i),
    .stall_req_id_i (stall_req_id_i),
    .flush_i        (flush_i),
    .hilo_wdata_o   (hilo_wdata_o),
    .done_o         (done_o),
    .stall_req_ex_o (stall_req_ex_o),
    .stall_o        (stall_o),
    .cnt_o          (cnt_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: accumulator is {HI,LO}; add or subtract the product mod 2^64
  function automatic logic [63:0] refResult(input logic [7:0] op, input logic [63:0] prod,
                                            input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] acc;
    acc = {hi, lo};
    if (op == OP_MSUB || op == OP_MSUBU) return acc - prod;
    return acc + prod;
  endfunction

  function automatic logic [5:0] refIdleStall(input logic id);
    return id ? 6'b000111 : 6'b000000;
  endfunction

  // Apply one cycle's worth of inputs
  task automatic applyStimulus(input logic [7:0] op, input logic [63:0] prod,
                               input logic [31:0] hi, input logic [31:0] lo,
                               input logic id, input logic fl);
    aluop_i        = op;
    mul_result_i   = prod;
    hi_i           = hi;
    lo_i           = lo;
    stall_req_id_i = id;
    flush_i        = fl;
  endtask

  // Move to just after the next rising edge, then settle to mid-cycle
  task automatic nextCycle();
    @(posedge Clk);
    #1;
  endtask

  // Reset held with a madd op and an ID stall present: everything must stay 0
  task automatic test_reset();
    Rst_n = 1'b0;
    applyStimulus(OP_MADD, 64'h1234, 32'h1, 32'h2, 1'b1, 1'b0);
    #3;
    checks++;
    if (stall_req_ex_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 6'b0 ||
        hilo_wdata_o !== 64'h0 || cnt_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got stallEx=%b done=%b stall=%b hilo=%h cnt=%0d required all 0",
               stall_req_ex_o, done_o, stall_o, hilo_wdata_o, cnt_o);
    end
    applyStimulus(OP_NOP, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    Rst_n = 1'b1;
    nextCycle();
    #3;
    checks++;
    if (cnt_o !== 2'd0 || done_o !== 1'b0 || stall_o !== 6'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got cnt=%0d done=%b stall=%b required 0/0/000000",
               cnt_o, done_o, stall_o);
    end
    nextCycle();
  endtask

  // Test-plan cases: MADD, MSUB and the MADDU wraparound
  task automatic test_directed();
    logic [7:0]  ops   [3] = '{OP_MADD, OP_MSUB, OP_MADDU};
    logic [63:0] prods [3] = '{64'h6, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [31:0] los   [3] = '{32'd10, 32'd3, 32'd1};
    logic [63:0] want  [3] = '{64'h10, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ops[i], prods[i], 32'h0, los[i], 1'b0, 1'b0);
      #3;
      checks++;
      if (stall_req_ex_o !== 1'b1 || stall_o !== 6'b001111 || done_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed%0d_cycle1: got stallEx=%b stall=%b done=%b required 1/001111/0",
                 i, stall_req_ex_o, stall_o, done_o);
      end
      nextCycle();
      #3;
      checks++;
      if (done_o !== 1'b1 || hilo_wdata_o !== want[i] || stall_o !== 6'b000000 || cnt_o !== 2'd1) begin
        errors++;
        $display("[TB] FAIL directed%0d_cycle2: got done=%b hilo=%h stall=%b cnt=%0d required 1/%h/000000/1",
                 i, done_o, hilo_wdata_o, stall_o, cnt_o, want[i]);
      end
      nextCycle();
      applyStimulus(OP_NOP, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      nextCycle();
    end
  endtask

  // Two MADDs in a row, the second seeing HI/LO forwarded from the first
  task automatic test_back_to_back();
    logic        expEx   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        expDone [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] prod    [4] = '{64'd2, 64'd2, 64'd3, 64'd3};
    logic [31:0] lo      [4] = '{32'd0, 32'd0, 32'd2, 32'd2};
    logic [63:0] expHilo [4] = '{64'd0, 64'd2, 64'd0, 64'd5};
    for (int c = 0; c < 4; c++) begin
      applyStimulus(OP_MADD, prod[c], 32'h0, lo[c], 1'b0, 1'b0);
      #3;
      checks++;
      if (stall_req_ex_o !== expEx[c] || done_o !== expDone[c] || hilo_wdata_o !== expHilo[c]) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d: got stallEx=%b done=%b hilo=%h required %b/%b/%h",
                 c + 1, stall_req_ex_o, done_o, hilo_wdata_o, expEx[c], expDone[c], expHilo[c]);
      end
      nextCycle();
    end
    applyStimulus(OP_NOP, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    nextCycle();
  endtask

  // ID stall alone, and ID stall overlapping the EX stall
  task automatic test_stall_merge();
    applyStimulus(OP_NOP, 64'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    #3;
    checks++;
    if (stall_o !== 6'b000111) begin
      errors++;
      $display("[TB] FAIL stall_id_only: got %b required 000111", stall_o);
    end
    nextCycle();
    applyStimulus(OP_MADDU, 64'h7, 32'h0, 32'h1, 1'b1, 1'b0);
    #3;
    checks++;
    if (stall_o !== 6'b001111) begin
      errors++;
      $display("[TB] FAIL stall_both: got %b required 001111", stall_o);
    end
    nextCycle();
    #3;
    checks++;
    if (stall_o !== 6'b000111 || done_o !== 1'b1 || hilo_wdata_o !== 64'h8) begin
      errors++;
      $display("[TB] FAIL stall_id_acc: got stall=%b done=%b hilo=%h required 000111/1/8",
               stall_o, done_o, hilo_wdata_o);
    end
    nextCycle();
    applyStimulus(OP_NOP, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    nextCycle();
  endtask

  // Flush in ACC kills the result; flush in IDLE blocks the start
  task automatic test_flush();
    applyStimulus(OP_MADD, 64'h9, 32'h0, 32'h1, 1'b0, 1'b0);
    nextCycle();
    flush_i = 1'b1;
    #3;
    checks++;
    if (done_o !== 1'b0 || stall_req_ex_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_acc: got done=%b stallEx=%b required 0/0", done_o, stall_req_ex_o);
    end
    nextCycle();
    applyStimulus(OP_NOP, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    checks++;
    if (cnt_o !== 2'd0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_acc_idle: got cnt=%0d done=%b required 0/0", cnt_o, done_o);
    end
    nextCycle();
    applyStimulus(OP_MSUB, 64'h9, 32'h0, 32'h1, 1'b0, 1'b1);
    #3;
    checks++;
    if (stall_req_ex_o !== 1'b0 || stall_o !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL flush_idle: got stallEx=%b stall=%b required 0/000000", stall_req_ex_o, stall_o);
    end
    nextCycle();
    applyStimulus(OP_NOP, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #3;
    checks++;
    if (cnt_o !== 2'd0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_idle_next: got cnt=%0d done=%b required 0/0", cnt_o, done_o);
    end
    nextCycle();
  endtask

  // Reset pulsed low during ACC discards the sequence immediately
  task automatic test_reset_mid();
    applyStimulus(OP_MADD, 64'h55, 32'h1, 32'h1, 1'b0, 1'b0);
    nextCycle();
    #1;
    Rst_n = 1'b0;
    #1;
    checks++;
    if (done_o !== 1'b0 || hilo_wdata_o !== 64'h0 || stall_o !== 6'b0 ||
        stall_req_ex_o !== 1'b0 || cnt_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got done=%b hilo=%h stall=%b stallEx=%b cnt=%0d required all 0",
               done_o, hilo_wdata_o, stall_o, stall_req_ex_o, cnt_o);
    end
    applyStimulus(OP_NOP, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    Rst_n = 1'b1;
    nextCycle();
    #3;
    checks++;
    if (cnt_o !== 2'd0 || done_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_after: got cnt=%0d done=%b required 0/0", cnt_o, done_o);
    end
    nextCycle();
  endtask

  // Random mix of idle cycles and madd-class sequences against the model
  task automatic test_random();
    logic [7:0]  ops [4] = '{OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    logic [7:0]  op;
    logic [63:0] prod;
    logic [31:0] hi, lo;
    logic        id;
    logic [63:0] want;
    for (int n = 0; n < 200; n++) begin
      id = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        op = 8'($urandom);
        if (op == OP_MADD || op == OP_MADDU || op == OP_MSUB || op == OP_MSUBU) op = OP_NOP;
        applyStimulus(op, {$urandom, $urandom}, $urandom, $urandom, id, 1'b0);
        #3;
        checks++;
        if (stall_req_ex_o !== 1'b0 || done_o !== 1'b0 || hilo_wdata_o !== 64'h0 ||
            cnt_o !== 2'd0 || stall_o !== refIdleStall(id)) begin
          errors++;
          $display("[TB] FAIL rand%0d_idle: got stallEx=%b done=%b hilo=%h cnt=%0d stall=%b required 0/0/0/0/%b",
                   n, stall_req_ex_o, done_o, hilo_wdata_o, cnt_o, stall_o, refIdleStall(id));
        end
        nextCycle();
      end else begin
        op   = ops[$urandom_range(0, 3)];
        prod = {$urandom, $urandom};
        applyStimulus(op, prod, $urandom, $urandom, id, 1'b0);
        #3;
        checks++;
        if (stall_req_ex_o !== 1'b1 || stall_o !== 6'b001111 || done_o !== 1'b0 || cnt_o !== 2'd0) begin
          errors++;
          $display("[TB] FAIL rand%0d_start: got stallEx=%b stall=%b done=%b cnt=%0d required 1/001111/0/0",
                   n, stall_req_ex_o, stall_o, done_o, cnt_o);
        end
        nextCycle();
        hi   = $urandom;
        lo   = $urandom;
        id   = 1'($urandom_range(0, 1));
        want = refResult(op, prod, hi, lo);
        applyStimulus(op, 64'($urandom), hi, lo, id, 1'b0);
        #3;
        checks++;
        if (done_o !== 1'b1 || hilo_wdata_o !== want || stall_req_ex_o !== 1'b0 ||
            cnt_o !== 2'd1 || stall_o !== refIdleStall(id)) begin
          errors++;
          $display("[TB] FAIL rand%0d_acc: got done=%b hilo=%h stallEx=%b cnt=%0d stall=%b required 1/%h/0/1/%b",
                   n, done_o, hilo_wdata_o, stall_req_ex_o, cnt_o, stall_o, want, refIdleStall(id));
        end
        nextCycle();
        applyStimulus(OP_NOP, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
      end
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall_merge();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
